// File: rtl/div_result_bcd.sv
// Signed binary to sign + packed BCD converter for the divider's result word.
// Iterative shift-add-3 (double dabble), one magnitude bit per clock.
module div_result_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  ready,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);

  function automatic int min_digits(input int w);
    longint unsigned lim, p;
    int d;
    lim = 64'd1 << (w-1);
    p   = 64'd1;
    d   = 0;
    for (int i = 0; i < 20; i++)
      if (p < lim) begin
        p = p * 10;
        d++;
      end
    return d;
  endfunction

  generate
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
      $error("div_result_bcd: DIGITS too small to hold 2^(WIDTH-1)");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_mag, w_mag_nxt;
  logic [BW-1:0]   r_scr, w_scr_nxt, w_adj;
  logic            r_neg_cap, w_neg_cap_nxt;
  logic            w_load;

  // Per-digit add-3 correction applied before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    assign w_adj[4*g +: 4] = (r_scr[4*g +: 4] >= 4'd5) ? r_scr[4*g +: 4] + 4'd3
                                                      : r_scr[4*g +: 4];
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mag_nxt     = r_mag;
    w_scr_nxt     = r_scr;
    w_neg_cap_nxt = r_neg_cap;
    w_load        = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt   = S_SHIFT;
        w_cnt_nxt     = CW'(WIDTH);
        // Unsigned negate: the most negative value maps to 2^(WIDTH-1) cleanly.
        w_mag_nxt     = value[WIDTH-1] ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
        w_scr_nxt     = '0;
        w_neg_cap_nxt = value[WIDTH-1];
      end
      S_SHIFT: begin
        {w_scr_nxt, w_mag_nxt} = {w_adj[BW-2:0], r_mag, 1'b0};
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mag     <= '0;
      r_scr     <= '0;
      r_neg_cap <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
      neg       <= 1'b0;
      bcd       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mag     <= w_mag_nxt;
      r_scr     <= w_scr_nxt;
      r_neg_cap <= w_neg_cap_nxt;
      ready     <= (w_state_nxt == S_IDLE);
      done      <= (w_state_nxt == S_DONE);
      if (w_load) begin
        bcd <= w_scr_nxt;
        neg <= r_neg_cap;
      end
    end
  end
endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Sequential signed binary-to-BCD converter sitting directly downstream of the `BoothsDiv` divider. It captures one signed result word, such as the 16-bit quotient or the sign-extended remainder. It then produces a sign flag plus packed BCD magnitude digits for the seven-segment display driver. Conversion is iterative shift-add-3 (double dabble), one bit per clock, using a start/ready/done handshake.

## Interface
- `WIDTH`, default 16: width of the signed input word; matches `BoothsDiv` quotient width (`bits`+1 with `bits`=15).
- `DIGITS`, default 5: number of BCD output digits; must satisfy 10^DIGITS ≥ 2^(WIDTH-1). Elaboration fails (`$error`/generate check) otherwise.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: request conversion of `value`; honoured only while `ready`=1.
- `value` input WIDTH: signed two's-complement operand, sampled on the accepting edge only.
- `ready` output 1: high in IDLE only.
- `done` output 1: one-cycle pulse marking new `bcd`/`neg` valid.
- `neg` output 1: sign of last converted value (1 = negative, never set for zero).
- `bcd` output 4*DIGITS: packed magnitude digits, most significant digit in the top nibble.

## Operation
- States:
  - IDLE: `ready`=1. `start`=1 at an edge → capture, go to SHIFT.
  - SHIFT: WIDTH iterations. Then go to DONE.
  - DONE: `done`=1 for exactly one cycle. Then go to IDLE.
- Capture on the accepting edge:
  - `neg_r` = `value`[WIDTH-1].
  - `mag` = |`value|`, computed as an unsigned WIDTH-bit negate. For -2^(WIDTH-1) (-32768), `mag` = 0x8000 with no overflow.
  - BCD scratch register is cleared and the iteration counter is loaded with WIDTH.
- Each SHIFT cycle:
  - Every scratch nibble ≥5 gets +3.
  - The {scratch, `mag`} register is shifted left by 1.
  - The counter is decremented.
  - Add-3 and shift form one combinational step registered in a single edge.
- On the last SHIFT edge (counter reaches 0), the registered outputs are updated and the state moves to DONE:
  - `bcd` ← scratch.
  - `neg` ← `neg_r`.
- `bcd` and `neg` hold the last completed result until the next completion. They are not cleared by `start`.
- `start` while not in IDLE (SHIFT or DONE) is ignored and not queued; `value` is not re-sampled.
- `start` held high continuously converts back-to-back: each return to IDLE accepts on that edge.
- `rst` asserted at any time, including mid-SHIFT:
  - Aborts immediately and returns to IDLE.
  - Outputs take reset values. No `done` is produced for the aborted conversion.

## Timing
- Reset values: `ready`=1, `done`=0, `neg`=0, `bcd`=0; state IDLE, counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Let E0 be the edge where `start`&&`ready`:
  - `ready` falls after E0.
  - Outputs update at edge E(WIDTH), i.e. E16 by default.
  - `done`=1 during the cycle between E(WIDTH) and E(WIDTH+1).
  - `ready` returns to 1 after E(WIDTH+1).
- Throughput: one conversion per WIDTH+2 cycles (18 by default).
- `done` and `ready` are never high in the same cycle.

## Test plan
- Reset, then `value`=0, `start` pulse:
  - `ready` low 17 cycles.
  - `done` exactly 16 cycles after the accepting edge.
  - `bcd`=0x00000, `neg`=0.
- `value`=12345 → `bcd`=0x12345, `neg`=0. Then `value`=-1 → `bcd`=0x00001, `neg`=1. Then `value`=32767 → `bcd`=0x32767, `neg`=0.
- `value`=-32768 → `bcd`=0x32768, `neg`=1.
- Pulse `start` with `value`=999 at cycle 5 of a conversion of 42:
  - Result 0x00042.
  - Only one `done`.
  - `ready` timing unchanged.
- Assert `rst` at cycle 8 of converting -500:
  - Outputs immediately 0, `ready`=1.
  - No `done`.
  - A following conversion of 77 yields 0x00077, `neg`=0.
- `start` held high, `value` driven by the negedge-updated divider-quotient counter:
  - Each `done` result equals sign/magnitude of the value sampled 16 cycles earlier.
  - Accepts spaced exactly 18 cycles.
  - Sweep all 65536 values with no mismatch.
